// File: rtl/nfc_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nfc_ram_pkg
// Description : Shared types, constants and helpers for the NFC asymmetric
//               simple-dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package nfc_ram_pkg;

    localparam int RD_LAT_MAX = 3;

    // Lane index within a wide read word (RATIO up to 8).
    typedef logic [2:0] lane_idx_t;

    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_BUSY = 1'b1
    } clr_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nfc_asym_sdp_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : nfc_asym_sdp_ram_if
// Description : Write/read/clear bus of the NFC asymmetric SDP RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface nfc_asym_sdp_ram_if
    import nfc_ram_pkg::*;
#(
    parameter int WR_DW = 16,
    parameter int RATIO = 2,
    parameter int WR_AW = 14
);
    localparam int c_RD_DW = WR_DW * RATIO;
    localparam int c_RD_AW = WR_AW - clog2(RATIO);

    logic                 wr_en;
    logic [WR_AW-1:0]     wr_addr;
    logic [WR_DW-1:0]     wr_data;
    logic                 wr_pinj;
    logic                 rd_en;
    logic [c_RD_AW-1:0]   rd_addr;
    logic [c_RD_DW-1:0]   rd_data;
    logic                 rd_valid;
    logic [RATIO-1:0]     rd_perr;
    logic                 clr_start;
    logic                 clr_busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_pinj, rd_en, rd_addr, clr_start,
        input  rd_data, rd_valid, rd_perr, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_pinj, rd_en, rd_addr, clr_start,
        output rd_data, rd_valid, rd_perr, clr_busy
    );

endinterface
`default_nettype wire

// File: rtl/nfc_ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : nfc_ram_rd_pipe
// Description : LAT-deep valid/data/parity-error delay line; stage 0 is the
//               array read register. Data stages only load behind a valid.
// Revision    : 1.0 - initial release
// ============================================================================
module nfc_ram_rd_pipe #(
    parameter int DW  = 32,
    parameter int PW  = 2,
    parameter int LAT = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_valid,
    input  wire logic [DW-1:0] i_data,
    input  wire logic [PW-1:0] i_perr,
    output logic               o_valid,
    output logic [DW-1:0]      o_data,
    output logic [PW-1:0]      o_perr
);

    logic [LAT-1:0]         r_v;
    logic [LAT-1:0][DW-1:0] r_d;
    logic [LAT-1:0][PW-1:0] r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_d <= '0;
            r_p <= '0;
        end else begin
            r_v[0] <= i_valid;
            if (i_valid) begin
                r_d[0] <= i_data;
                r_p[0] <= i_perr;
            end
            for (int s = 1; s < LAT; s++) begin
                r_v[s] <= r_v[s-1];
                if (r_v[s-1]) begin
                    r_d[s] <= r_d[s-1];
                    r_p[s] <= r_p[s-1];
                end
            end
        end
    end

    assign o_valid = r_v[LAT-1];
    assign o_data  = r_d[LAT-1];
    assign o_perr  = r_v[LAT-1] ? r_p[LAT-1] : '0;

endmodule
`default_nettype wire

// File: rtl/nfc_asym_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : nfc_asym_sdp_ram
// Description : Asymmetric SDP RAM (narrow write, RATIO-lane wide read) with
//               read latency, read-first collision and a zero-fill sequencer.
//               Optional word parity: define NFC_SDPRAM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nfc_asym_sdp_ram
    import nfc_ram_pkg::*;
#(
    parameter int WR_DW  = 16,
    parameter int RATIO  = 2,
    parameter int WR_AW  = 14,
    parameter int RD_LAT = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nfc_asym_sdp_ram_if.slave bus
);

    localparam int c_LW    = clog2(RATIO);
    localparam int c_RD_DW = WR_DW * RATIO;
    localparam int c_DEPTH = 2 ** WR_AW;
`ifdef NFC_SDPRAM_PARITY_EN
    localparam int c_MW    = WR_DW + 1;
`else
    localparam int c_MW    = WR_DW;
`endif

    logic [c_MW-1:0]    r_mem [c_DEPTH];

    clr_state_e         r_state;
    clr_state_e         w_state_nxt;
    logic [WR_AW-1:0]   r_cnt;
    logic               w_busy;

    logic               w_we;
    logic [WR_AW-1:0]   w_waddr;
    logic [c_MW-1:0]    w_wword;
    logic [c_MW-1:0]    w_user_word;

    logic [c_RD_DW-1:0] w_rd_word;
    logic [RATIO-1:0]   w_rd_perr;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLR_BUSY) r_cnt <= r_cnt + 1'b1;
            else                     r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLR_IDLE: if (bus.clr_start)            w_state_nxt = CLR_BUSY;
            CLR_BUSY: if (r_cnt == {WR_AW{1'b1}})   w_state_nxt = CLR_IDLE;
            default:                                w_state_nxt = CLR_IDLE;
        endcase
    end

    assign w_busy       = (r_state == CLR_BUSY);
    assign bus.clr_busy = w_busy;

    // ---------------- write path ----------------
`ifdef NFC_SDPRAM_PARITY_EN
    assign w_user_word = {^bus.wr_data ^ bus.wr_pinj, bus.wr_data};
`else
    logic w_unused_pinj;
    assign w_unused_pinj = bus.wr_pinj;
    assign w_user_word   = bus.wr_data;
`endif

    // Clear owns the port while busy; nothing lands during reset so a reset
    // mid-sweep leaves exactly the words already swept cleared.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.wr_addr;
        w_wword = w_user_word;
        if (!rst) begin
            if (w_busy) begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wword = '0;
            end else if (bus.wr_en) begin
                w_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wword;
    end

    // ---------------- read lanes (read-first: array sampled before the edge) ----
    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        logic [WR_AW-1:0] w_laddr;
        logic [c_MW-1:0]  w_lword;

        if (RATIO == 1) begin : g_direct
            assign w_laddr = bus.rd_addr;
        end else begin : g_concat
            assign w_laddr = {bus.rd_addr, c_LW'(i)};
        end

        assign w_lword = r_mem[w_laddr];
        assign w_rd_word[i*WR_DW +: WR_DW] = w_lword[WR_DW-1:0];
`ifdef NFC_SDPRAM_PARITY_EN
        assign w_rd_perr[i] = ^w_lword;
`else
        assign w_rd_perr[i] = 1'b0;
`endif
    end

    nfc_ram_rd_pipe #(
        .DW  (c_RD_DW),
        .PW  (RATIO),
        .LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.rd_en),
        .i_data  (w_rd_word),
        .i_perr  (w_rd_perr),
        .o_valid (bus.rd_valid),
        .o_data  (bus.rd_data),
        .o_perr  (bus.rd_perr)
    );

endmodule
`default_nettype wire

// File: tb/tb_nfc_asym_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_nfc_asym_sdp_ram
// Description : Directed self-checking bench with a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nfc_asym_sdp_ram;

    localparam int WR_DW  = 16;
    localparam int RATIO  = 2;
    localparam int WR_AW  = 4;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 16;
`ifdef NFC_SDPRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nfc_asym_sdp_ram_if #(.WR_DW(WR_DW), .RATIO(RATIO), .WR_AW(WR_AW)) bus ();

    nfc_asym_sdp_ram #(
        .WR_DW(WR_DW), .RATIO(RATIO), .WR_AW(WR_AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  perr;
    } rd_t;

    logic [15:0] m_mem  [DEPTH];
    logic        m_pinj [DEPTH];
    rd_t         m_q[$];
    rd_t         m_e;
    int          cyc       = 0;
    bit          m_busy    = 0;
    int          m_clr_idx = 0;
    logic [31:0] m_last    = '0;
    bit          chk_en    = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            m_busy = 0;
            m_last = '0;
        end else begin
            if (bus.rd_en) begin
                m_e.due = cyc + RD_LAT - 1;
                for (int i = 0; i < RATIO; i++) begin
                    m_e.data[i*16 +: 16] = m_mem[int'(bus.rd_addr)*RATIO + i];
                    m_e.perr[i]          = m_pinj[int'(bus.rd_addr)*RATIO + i];
                end
                m_q.push_back(m_e);
            end
            if (m_busy) begin
                m_mem[m_clr_idx]  = '0;
                m_pinj[m_clr_idx] = 1'b0;
                m_clr_idx++;
                if (m_clr_idx == DEPTH) m_busy = 0;
            end else begin
                if (bus.wr_en) begin
                    m_mem[bus.wr_addr]  = bus.wr_data;
                    m_pinj[bus.wr_addr] = bus.wr_pinj;
                end
                if (bus.clr_start) begin
                    m_busy    = 1;
                    m_clr_idx = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_v;
            exp_v = (m_q.size() > 0) && (m_q[0].due == cyc);
            check("rd_valid", 64'(bus.rd_valid), 64'(exp_v));
            if (exp_v) begin
                m_e    = m_q.pop_front();
                m_last = m_e.data;
                check("rd_perr", 64'(bus.rd_perr), PAR ? 64'(m_e.perr) : 64'd0);
            end
            check("rd_data", 64'(bus.rd_data), 64'(m_last));
            check("clr_busy", 64'(bus.clr_busy), 64'(m_busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d, input logic pinj);
        bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_data = d; bus.wr_pinj = pinj;
        tick();
        bus.wr_en = 1'b0; bus.wr_pinj = 1'b0;
    endtask

    // Issue one read and return once its result is visible.
    task automatic rd(input int a);
        bus.rd_en = 1'b1; bus.rd_addr = 3'(a);
        tick();
        bus.rd_en = 1'b0;
        repeat (RD_LAT - 1) tick();
    endtask

    initial begin
        int n;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_pinj = 0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.clr_start = 0;
        repeat (3) tick();
        check("reset rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset rd_data",  64'(bus.rd_data),  64'd0);
        check("reset rd_perr",  64'(bus.rd_perr),  64'd0);
        check("reset clr_busy", 64'(bus.clr_busy), 64'd0);
        rst = 1'b0;
        chk_en = 1;

        // Known array contents to start from.
        bus.clr_start = 1; tick(); bus.clr_start = 0;
        repeat (DEPTH) tick();

        // Basic wide read.
        wr(0, 16'h1111, 0);
        wr(1, 16'h2222, 0);
        rd(0);
        check("t1 rd_valid", 64'(bus.rd_valid), 64'd1);
        check("t1 rd_data",  64'(bus.rd_data),  64'h2222_1111);

        // Back-to-back reads, full throughput.
        for (int w = 2; w < DEPTH; w++) wr(w, 16'(w * 16'h0101), 0);
        n = 0;
        for (int a = 0; a < 8 + RD_LAT; a++) begin
            bus.rd_en = (a < 8); bus.rd_addr = 3'(a);
            tick();
            if (bus.rd_valid) n++;
        end
        bus.rd_en = 0;
        check("t2 valid pulses", 64'(n), 64'd8);

        // Read/write collision is read-first.
        bus.wr_en = 1; bus.wr_addr = 4'd1; bus.wr_data = 16'hBEEF;
        bus.rd_en = 1; bus.rd_addr = 3'd0;
        tick();
        bus.wr_en = 0; bus.rd_en = 0;
        repeat (RD_LAT - 1) tick();
        check("t3 collision", 64'(bus.rd_data), 64'h2222_1111);
        rd(0);
        check("t3 after write", 64'(bus.rd_data), 64'hBEEF_1111);

        // Parity injection on one word.
        wr(2, 16'h00FF, 1);
        rd(1);
        check("t6 rd_data", 64'(bus.rd_data), 64'h0303_00FF);
        check("t6 rd_perr", 64'(bus.rd_perr), PAR ? 64'd1 : 64'd0);

        // Clear sweep; user writes and re-starts during the sweep are dropped.
        bus.clr_start = 1; tick(); bus.clr_start = 0;
        n = 0;
        while (bus.clr_busy && n < 100) begin
            bus.wr_en = 1; bus.wr_addr = 4'd5; bus.wr_data = 16'hAAAA;
            bus.clr_start = (n == 3);
            tick();
            n++;
        end
        bus.wr_en = 0; bus.clr_start = 0;
        check("t4 busy cycles", 64'(n), 64'd16);
        for (int a = 0; a < 8; a++) rd(a);
        rd(2);
        check("t4 cleared", 64'(bus.rd_data), 64'd0);

        // Reset squashes an in-flight read.
        bus.rd_en = 1; bus.rd_addr = 3'd1; tick(); bus.rd_en = 0;
        tick();
        rst = 1; tick();
        check("t5 squashed valid", 64'(bus.rd_valid), 64'd0);
        rst = 0; tick();

        // Reset mid-sweep leaves a partially cleared array.
        for (int w = 0; w < DEPTH; w++) wr(w, 16'hA000 + 16'(w), 0);
        bus.clr_start = 1; tick(); bus.clr_start = 0;
        repeat (5) tick();
        rst = 1; tick();
        check("t5 busy after reset", 64'(bus.clr_busy), 64'd0);
        rst = 0; tick();
        for (int a = 0; a < 8; a++) rd(a);
        rd(2);
        check("t5 partial clear", 64'(bus.rd_data), 64'hA005_0000);

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
